// File: rtl/msix_pkg.sv
// Shared constants, state encoding and helpers for the MSI-X capability engine.
package msix_pkg;

    localparam logic [7:0] MSIX_CAP_ID   = 8'h11;

    localparam logic [1:0] MSIX_DW_CTRL  = 2'd0;
    localparam logic [1:0] MSIX_DW_TABLE = 2'd1;
    localparam logic [1:0] MSIX_DW_PBA   = 2'd2;

    localparam int unsigned MSIX_ENABLE_BIT = 31;
    localparam int unsigned MSIX_FMASK_BIT  = 30;

    localparam logic [2:0] MSIX_MAX_BIR_T0 = 3'd5;
    localparam logic [2:0] MSIX_MAX_BIR_T1 = 3'd1;

    typedef enum logic {IDLE, ISSUE} msix_state_e;

    // Table spans 16 bytes per vector, the PBA qword 8 bytes; widened to avoid wrap.
    function automatic logic msix_overlap(logic [31:0] tbl_off, logic [31:0] pba_off,
                                          int unsigned num_vec);
        logic [33:0] w_tbl_lo;
        logic [33:0] w_tbl_hi;
        logic [33:0] w_pba_lo;
        logic [33:0] w_pba_hi;
        w_tbl_lo = {2'b00, tbl_off};
        w_tbl_hi = w_tbl_lo + 34'(16 * num_vec);
        w_pba_lo = {2'b00, pba_off};
        w_pba_hi = w_pba_lo + 34'd8;
        return (w_tbl_lo < w_pba_hi) && (w_pba_lo < w_tbl_hi);
    endfunction

endpackage

// File: rtl/msix_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module msix_rr_arbiter
    import msix_pkg::*;
#(
    parameter int unsigned N  = 8,
    parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] gnt_idx,
    output logic          any_gnt
);

    int          w_idx;
    logic [IW-1:0] w_sel;

    // Scan from farthest to nearest so the closest request to ptr wins last.
    always_comb begin
        gnt_idx = '0;
        any_gnt = 1'b0;
        w_idx   = 0;
        w_sel   = '0;
        for (int k = int'(N) - 1; k >= 0; k--) begin
            w_idx = (int'(ptr) + k) % int'(N);
            w_sel = IW'(w_idx);
            if (req[w_sel]) begin
                gnt_idx = w_sel;
                any_gnt = 1'b1;
            end
        end
    end

endmodule

// File: rtl/msix_cap_engine.sv
// MSI-X capability registers, per-vector mask/pending state and round-robin message issue.
module msix_cap_engine
    import msix_pkg::*;
#(
    parameter int unsigned NUM_VECTORS  = 8,
    parameter logic [31:0] TABLE_OFFSET = 32'h0000_0000,
    parameter logic [2:0]  TABLE_BIR    = 3'd0,
    parameter logic [31:0] PBA_OFFSET   = 32'h0000_0800,
    parameter logic [2:0]  PBA_BIR      = 3'd0,
    parameter bit          TYPE1        = 1'b0,
    parameter logic [7:0]  NEXT_PTR     = 8'h00,
    parameter int unsigned IDX_W        = (NUM_VECTORS > 1) ? $clog2(NUM_VECTORS) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cfg_rd_en,
    input  logic                   cfg_wr_en,
    input  logic [1:0]             cfg_addr,
    input  logic [3:0]             cfg_byte_en,
    input  logic [31:0]            cfg_wdata,
    output logic [31:0]            cfg_rdata,
    output logic                   cfg_rd_valid,
    input  logic                   vec_mask_wr_en,
    input  logic [IDX_W-1:0]       vec_mask_idx,
    input  logic                   vec_mask_wdata,
    output logic [63:0]            pba_rdata,
    input  logic [NUM_VECTORS-1:0] irq_req,
    output logic                   msg_valid,
    output logic [IDX_W-1:0]       msg_vector,
    input  logic                   msg_ready,
    output logic                   msix_enable,
    output logic                   function_mask,
    output logic                   param_error
);

    localparam logic [2:0]  MAX_BIR   = TYPE1 ? MSIX_MAX_BIR_T1 : MSIX_MAX_BIR_T0;
    localparam logic [10:0] TBL_SIZE  = 11'(NUM_VECTORS - 1);
    localparam bit          PARAM_ERR = (TABLE_BIR > MAX_BIR) || (PBA_BIR > MAX_BIR) ||
                                        (TABLE_OFFSET[2:0] != 3'd0) ||
                                        (PBA_OFFSET[2:0] != 3'd0) ||
                                        ((TABLE_BIR == PBA_BIR) &&
                                         msix_overlap(TABLE_OFFSET, PBA_OFFSET, NUM_VECTORS));

    logic                   r_enable;
    logic                   r_fmask;
    logic [NUM_VECTORS-1:0] r_mask;
    logic [NUM_VECTORS-1:0] r_pending;
    msix_state_e            r_state;
    logic                   r_msg_valid;
    logic [IDX_W-1:0]       r_msg_vector;
    logic [IDX_W-1:0]       r_rr_ptr;
    logic [31:0]            r_cfg_rdata;
    logic                   r_cfg_rd_valid;

    logic                   w_ctrl_wr;
    logic                   w_enable_d;
    logic                   w_fmask_d;
    logic [31:0]            w_rd_mux;
    logic                   w_handshake;
    logic [NUM_VECTORS-1:0] w_clr;
    logic [NUM_VECTORS-1:0] w_pending_d;
    logic [NUM_VECTORS-1:0] w_eligible;
    logic [IDX_W-1:0]       w_gnt_idx;
    logic                   w_any_gnt;
    logic                   w_unused_cfg;

    assign w_ctrl_wr    = cfg_wr_en && (cfg_addr == MSIX_DW_CTRL) && cfg_byte_en[3];
    assign w_enable_d   = w_ctrl_wr ? cfg_wdata[MSIX_ENABLE_BIT] : r_enable;
    assign w_fmask_d    = w_ctrl_wr ? cfg_wdata[MSIX_FMASK_BIT] : r_fmask;
    assign w_unused_cfg = ^{cfg_wdata[29:0], cfg_byte_en[2:0]};

    always_comb begin
        w_rd_mux = 32'd0;
        case (cfg_addr)
            MSIX_DW_CTRL:  w_rd_mux = {r_enable, r_fmask, 3'b000, TBL_SIZE, NEXT_PTR, MSIX_CAP_ID};
            MSIX_DW_TABLE: w_rd_mux = {TABLE_OFFSET[31:3], TABLE_BIR};
            MSIX_DW_PBA:   w_rd_mux = {PBA_OFFSET[31:3], PBA_BIR};
            default:       w_rd_mux = 32'd0;
        endcase
    end

    assign w_handshake = r_msg_valid & msg_ready;

    always_comb begin
        w_clr = '0;
        if (w_handshake) w_clr[r_msg_vector] = 1'b1;
    end

    // A new event on the vector being acknowledged survives the clear.
    assign w_pending_d = (r_pending & ~w_clr) | (irq_req & {NUM_VECTORS{r_enable}});
    assign w_eligible  = r_pending & ~r_mask & {NUM_VECTORS{r_enable & ~r_fmask}};

    msix_rr_arbiter #(
        .N  (NUM_VECTORS),
        .IW (IDX_W)
    ) u_arb (
        .req     (w_eligible),
        .ptr     (r_rr_ptr),
        .gnt_idx (w_gnt_idx),
        .any_gnt (w_any_gnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_enable       <= 1'b0;
            r_fmask        <= 1'b0;
            r_mask         <= '1;
            r_pending      <= '0;
            r_cfg_rdata    <= 32'd0;
            r_cfg_rd_valid <= 1'b0;
        end else begin
            r_enable       <= w_enable_d;
            r_fmask        <= w_fmask_d;
            r_pending      <= w_pending_d;
            r_cfg_rd_valid <= cfg_rd_en;
            if (cfg_rd_en) r_cfg_rdata <= w_rd_mux;
            if (vec_mask_wr_en && (32'(vec_mask_idx) < NUM_VECTORS)) begin
                r_mask[vec_mask_idx] <= vec_mask_wdata;
            end
        end
    end

    // Once presented, a message is only withdrawn by clearing Enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_msg_valid  <= 1'b0;
            r_msg_vector <= '0;
            r_rr_ptr     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any_gnt && w_enable_d) begin
                        r_msg_vector <= w_gnt_idx;
                        r_msg_valid  <= 1'b1;
                        r_state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (w_handshake) begin
                        r_msg_valid <= 1'b0;
                        r_state     <= IDLE;
                        r_rr_ptr    <= (32'(r_msg_vector) == NUM_VECTORS - 1) ? '0 :
                                       r_msg_vector + IDX_W'(1);
                    end else if (!w_enable_d) begin
                        r_msg_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_msg_valid <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign cfg_rdata     = r_cfg_rdata;
    assign cfg_rd_valid  = r_cfg_rd_valid;
    assign pba_rdata     = 64'(r_pending);
    assign msg_valid     = r_msg_valid;
    assign msg_vector    = r_msg_vector;
    assign msix_enable   = r_enable;
    assign function_mask = r_fmask;
    assign param_error   = PARAM_ERR;

endmodule

// File: tb/tb_msix_cap_engine.sv
// Directed self-checking bench for msix_cap_engine (8 vectors) plus two parameter-error builds.
module tb_msix_cap_engine;

    logic        clk;
    logic        rst_n;
    logic        cfg_rd_en;
    logic        cfg_wr_en;
    logic [1:0]  cfg_addr;
    logic [3:0]  cfg_byte_en;
    logic [31:0] cfg_wdata;
    logic [31:0] cfg_rdata;
    logic        cfg_rd_valid;
    logic        vec_mask_wr_en;
    logic [2:0]  vec_mask_idx;
    logic        vec_mask_wdata;
    logic [63:0] pba_rdata;
    logic [7:0]  irq_req;
    logic        msg_valid;
    logic [2:0]  msg_vector;
    logic        msg_ready;
    logic        msix_enable;
    logic        function_mask;
    logic        param_error;

    logic [31:0] p1_rdata, p2_rdata;
    logic        p1_rvld, p2_rvld, p1_mv, p2_mv, p1_en, p2_en, p1_fm, p2_fm, p1_err, p2_err;
    logic [63:0] p1_pba, p2_pba;
    logic [2:0]  p1_vec, p2_vec;

    int n_checks;
    int n_fail;

    msix_cap_engine u_dut (
        .clk(clk), .rst_n(rst_n), .cfg_rd_en(cfg_rd_en), .cfg_wr_en(cfg_wr_en),
        .cfg_addr(cfg_addr), .cfg_byte_en(cfg_byte_en), .cfg_wdata(cfg_wdata),
        .cfg_rdata(cfg_rdata), .cfg_rd_valid(cfg_rd_valid), .vec_mask_wr_en(vec_mask_wr_en),
        .vec_mask_idx(vec_mask_idx), .vec_mask_wdata(vec_mask_wdata), .pba_rdata(pba_rdata),
        .irq_req(irq_req), .msg_valid(msg_valid), .msg_vector(msg_vector),
        .msg_ready(msg_ready), .msix_enable(msix_enable), .function_mask(function_mask),
        .param_error(param_error)
    );

    msix_cap_engine #(.TYPE1(1'b1), .TABLE_BIR(3'd2)) u_err_t1 (
        .clk(clk), .rst_n(rst_n), .cfg_rd_en(cfg_rd_en), .cfg_wr_en(cfg_wr_en),
        .cfg_addr(cfg_addr), .cfg_byte_en(cfg_byte_en), .cfg_wdata(cfg_wdata),
        .cfg_rdata(p1_rdata), .cfg_rd_valid(p1_rvld), .vec_mask_wr_en(vec_mask_wr_en),
        .vec_mask_idx(vec_mask_idx), .vec_mask_wdata(vec_mask_wdata), .pba_rdata(p1_pba),
        .irq_req(irq_req), .msg_valid(p1_mv), .msg_vector(p1_vec), .msg_ready(msg_ready),
        .msix_enable(p1_en), .function_mask(p1_fm), .param_error(p1_err)
    );

    msix_cap_engine #(.TABLE_OFFSET(32'h0), .PBA_OFFSET(32'h40)) u_err_ovl (
        .clk(clk), .rst_n(rst_n), .cfg_rd_en(cfg_rd_en), .cfg_wr_en(cfg_wr_en),
        .cfg_addr(cfg_addr), .cfg_byte_en(cfg_byte_en), .cfg_wdata(cfg_wdata),
        .cfg_rdata(p2_rdata), .cfg_rd_valid(p2_rvld), .vec_mask_wr_en(vec_mask_wr_en),
        .vec_mask_idx(vec_mask_idx), .vec_mask_wdata(vec_mask_wdata), .pba_rdata(p2_pba),
        .irq_req(irq_req), .msg_valid(p2_mv), .msg_vector(p2_vec), .msg_ready(msg_ready),
        .msix_enable(p2_en), .function_mask(p2_fm), .param_error(p2_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Every task starts and ends just after a falling edge.
    task automatic reset_dut();
        cfg_rd_en = 0; cfg_wr_en = 0; cfg_addr = 0; cfg_byte_en = 0; cfg_wdata = 0;
        vec_mask_wr_en = 0; vec_mask_idx = 0; vec_mask_wdata = 0; irq_req = 0; msg_ready = 0;
        rst_n = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
    endtask

    task automatic cfg_write(input logic [1:0] a, input logic [31:0] d, input logic [3:0] be);
        cfg_addr = a; cfg_wdata = d; cfg_byte_en = be; cfg_wr_en = 1;
        @(negedge clk);
        cfg_wr_en = 0;
    endtask

    task automatic cfg_read(input logic [1:0] a, output logic [31:0] d, output logic v);
        cfg_addr = a; cfg_rd_en = 1;
        @(negedge clk);
        cfg_rd_en = 0;
        d = cfg_rdata; v = cfg_rd_valid;
    endtask

    task automatic mask_write(input logic [2:0] idx, input logic val);
        vec_mask_idx = idx; vec_mask_wdata = val; vec_mask_wr_en = 1;
        @(negedge clk);
        vec_mask_wr_en = 0;
    endtask

    task automatic pulse_irq(input logic [7:0] v);
        irq_req = v;
        @(negedge clk);
        irq_req = 0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic        v;
        logic [31:0] exp_rd [4];
        exp_rd = '{32'h0007_0011, 32'h0000_0000, 32'h0000_0800, 32'h0000_0000};
        reset_dut();
        n_checks++; if (msg_valid !== 1'b0) begin n_fail++; $display("FAIL reset_msg_valid: got %b expected 0", msg_valid); end
        n_checks++; if (msg_vector !== 3'd0) begin n_fail++; $display("FAIL reset_msg_vector: got %0d expected 0", msg_vector); end
        n_checks++; if ({msix_enable, function_mask} !== 2'b00) begin n_fail++; $display("FAIL reset_ctrl: got %b expected 00", {msix_enable, function_mask}); end
        n_checks++; if (pba_rdata !== 64'h0) begin n_fail++; $display("FAIL reset_pba: got %h expected 0", pba_rdata); end
        n_checks++; if ({cfg_rd_valid, cfg_rdata} !== 33'h0) begin n_fail++; $display("FAIL reset_cfg_rd: got %b/%h expected 0/0", cfg_rd_valid, cfg_rdata); end
        n_checks++; if (param_error !== 1'b0) begin n_fail++; $display("FAIL reset_param_error: got %b expected 0", param_error); end
        for (int i = 0; i < 4; i++) begin
            cfg_read(2'(i), d, v);
            n_checks++; if ({v, d} !== {1'b1, exp_rd[i]}) begin n_fail++; $display("FAIL reset_read_dw%0d: got %b/%h expected 1/%h", i, v, d, exp_rd[i]); end
        end
        @(negedge clk);
        n_checks++; if (cfg_rd_valid !== 1'b0) begin n_fail++; $display("FAIL rd_valid_drop: got %b expected 0", cfg_rd_valid); end
    endtask

    task automatic test_cfg_ro();
        logic [31:0] d;
        logic        v;
        reset_dut();
        cfg_write(2'd0, 32'hC000_0000, 4'h7);
        n_checks++; if ({msix_enable, function_mask} !== 2'b00) begin n_fail++; $display("FAIL be3_off_write: got %b expected 00", {msix_enable, function_mask}); end
        cfg_write(2'd1, 32'hFFFF_FFFF, 4'hF);
        cfg_read(2'd1, d, v);
        n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL dw1_ro: got %h expected 0", d); end
        cfg_addr = 2'd0; cfg_wdata = 32'hC000_0000; cfg_byte_en = 4'hF;
        cfg_wr_en = 1; cfg_rd_en = 1;
        @(negedge clk);
        cfg_wr_en = 0; cfg_rd_en = 0;
        n_checks++; if (cfg_rdata !== 32'h0007_0011) begin n_fail++; $display("FAIL rd_wr_same_cycle: got %h expected 00070011", cfg_rdata); end
        cfg_read(2'd0, d, v);
        n_checks++; if (d !== 32'hC007_0011) begin n_fail++; $display("FAIL dw0_after_write: got %h expected c0070011", d); end
    endtask

    task automatic test_fmask_gate();
        reset_dut();
        cfg_write(2'd0, 32'hC000_0000, 4'hF);
        n_checks++; if ({msix_enable, function_mask} !== 2'b11) begin n_fail++; $display("FAIL en_fmask_set: got %b expected 11", {msix_enable, function_mask}); end
        pulse_irq(8'h08);
        n_checks++; if (pba_rdata !== 64'h8) begin n_fail++; $display("FAIL pba_vec3: got %h expected 8", pba_rdata); end
        @(negedge clk);
        n_checks++; if (msg_valid !== 1'b0) begin n_fail++; $display("FAIL fmask_blocks: got %b expected 0", msg_valid); end
        cfg_write(2'd0, 32'h8000_0000, 4'hF);
        mask_write(3'd3, 1'b0);
        n_checks++; if (msg_valid !== 1'b0) begin n_fail++; $display("FAIL unmask_latency: got %b expected 0", msg_valid); end
        @(negedge clk);
        n_checks++; if ({msg_valid, msg_vector} !== {1'b1, 3'd3}) begin n_fail++; $display("FAIL vec3_msg: got %b/%0d expected 1/3", msg_valid, msg_vector); end
        msg_ready = 1;
        @(negedge clk);
        msg_ready = 0;
        n_checks++; if ({msg_valid, pba_rdata} !== 65'h0) begin n_fail++; $display("FAIL vec3_done: got %b/%h expected 0/0", msg_valid, pba_rdata); end
    endtask

    task automatic test_round_robin();
        logic [2:0] exp_v [3];
        exp_v = '{3'd1, 3'd2, 3'd5};
        reset_dut();
        cfg_write(2'd0, 32'h8000_0000, 4'hF);
        mask_write(3'd1, 1'b0);
        mask_write(3'd2, 1'b0);
        mask_write(3'd5, 1'b0);
        msg_ready = 1;
        pulse_irq(8'b0010_0110);
        n_checks++; if ({msg_valid, pba_rdata} !== {1'b0, 64'h26}) begin n_fail++; $display("FAIL rr_pending: got %b/%h expected 0/26", msg_valid, pba_rdata); end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_checks++; if ({msg_valid, msg_vector} !== {1'b1, exp_v[k]}) begin n_fail++; $display("FAIL rr_msg%0d: got %b/%0d expected 1/%0d", k, msg_valid, msg_vector, exp_v[k]); end
            @(negedge clk);
            n_checks++; if (msg_valid !== 1'b0) begin n_fail++; $display("FAIL rr_gap%0d: got %b expected 0", k, msg_valid); end
        end
        msg_ready = 0;
        n_checks++; if (pba_rdata !== 64'h0) begin n_fail++; $display("FAIL rr_pba_end: got %h expected 0", pba_rdata); end
    endtask

    task automatic test_stall();
        reset_dut();
        cfg_write(2'd0, 32'h8000_0000, 4'hF);
        mask_write(3'd2, 1'b0);
        pulse_irq(8'h04);
        @(negedge clk);
        n_checks++; if ({msg_valid, msg_vector} !== {1'b1, 3'd2}) begin n_fail++; $display("FAIL stall_start: got %b/%0d expected 1/2", msg_valid, msg_vector); end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_checks++; if ({msg_valid, msg_vector} !== {1'b1, 3'd2}) begin n_fail++; $display("FAIL stall_hold%0d: got %b/%0d expected 1/2", c, msg_valid, msg_vector); end
        end
        cfg_write(2'd0, 32'hC000_0000, 4'hF);
        n_checks++; if ({msg_valid, msg_vector} !== {1'b1, 3'd2}) begin n_fail++; $display("FAIL stall_fmask_hold: got %b/%0d expected 1/2", msg_valid, msg_vector); end
        cfg_write(2'd0, 32'h8000_0000, 4'hF);
        mask_write(3'd2, 1'b1);
        n_checks++; if ({msg_valid, msg_vector} !== {1'b1, 3'd2}) begin n_fail++; $display("FAIL stall_vmask_hold: got %b/%0d expected 1/2", msg_valid, msg_vector); end
        mask_write(3'd2, 1'b0);
        msg_ready = 1; irq_req = 8'h04;
        @(negedge clk);
        msg_ready = 0; irq_req = 8'h00;
        n_checks++; if ({msg_valid, pba_rdata} !== {1'b0, 64'h4}) begin n_fail++; $display("FAIL set_wins: got %b/%h expected 0/4", msg_valid, pba_rdata); end
        @(negedge clk);
        n_checks++; if ({msg_valid, msg_vector} !== {1'b1, 3'd2}) begin n_fail++; $display("FAIL second_msg: got %b/%0d expected 1/2", msg_valid, msg_vector); end
        msg_ready = 1;
        @(negedge clk);
        msg_ready = 0;
        n_checks++; if ({msg_valid, pba_rdata} !== 65'h0) begin n_fail++; $display("FAIL second_done: got %b/%h expected 0/0", msg_valid, pba_rdata); end
    endtask

    task automatic test_disable();
        reset_dut();
        cfg_write(2'd0, 32'h8000_0000, 4'hF);
        mask_write(3'd4, 1'b0);
        pulse_irq(8'h10);
        @(negedge clk);
        n_checks++; if ({msg_valid, msg_vector} !== {1'b1, 3'd4}) begin n_fail++; $display("FAIL dis_start: got %b/%0d expected 1/4", msg_valid, msg_vector); end
        cfg_write(2'd0, 32'h0000_0000, 4'hF);
        n_checks++; if ({msg_valid, msix_enable, pba_rdata} !== {2'b00, 64'h10}) begin n_fail++; $display("FAIL dis_withdraw: got %b/%b/%h expected 0/0/10", msg_valid, msix_enable, pba_rdata); end
        pulse_irq(8'h02);
        @(negedge clk);
        n_checks++; if ({msg_valid, pba_rdata} !== {1'b0, 64'h10}) begin n_fail++; $display("FAIL dis_irq_ignored: got %b/%h expected 0/10", msg_valid, pba_rdata); end
        cfg_write(2'd0, 32'h8000_0000, 4'hF);
        @(negedge clk);
        n_checks++; if ({msg_valid, msg_vector} !== {1'b1, 3'd4}) begin n_fail++; $display("FAIL reenable_msg: got %b/%0d expected 1/4", msg_valid, msg_vector); end
        rst_n = 0;
        #1;
        n_checks++; if ({msg_valid, msix_enable, pba_rdata} !== 66'h0) begin n_fail++; $display("FAIL mid_reset: got %b/%b/%h expected 0/0/0", msg_valid, msix_enable, pba_rdata); end
        msg_ready = 1;
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        msg_ready = 0;
        n_checks++; if (msg_valid !== 1'b0) begin n_fail++; $display("FAIL post_reset_idle: got %b expected 0", msg_valid); end
    endtask

    task automatic test_params();
        n_checks++; if (p1_err !== 1'b1) begin n_fail++; $display("FAIL param_type1_bir: got %b expected 1", p1_err); end
        n_checks++; if (p2_err !== 1'b1) begin n_fail++; $display("FAIL param_overlap: got %b expected 1", p2_err); end
        n_checks++; if (param_error !== 1'b0) begin n_fail++; $display("FAIL param_default: got %b expected 0", param_error); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 0;
        test_reset();
        test_cfg_ro();
        test_fmask_gate();
        test_round_robin();
        test_stall();
        test_disable();
        test_params();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/msix_cap_engine.md
Name: msix_cap_engine

Overview:
- Parametrised MSI-X capability engine for a PCIe function.
- Holds the capability header, Message Control, Table Offset/BIR and PBA Offset/BIR dwords, plus the per-vector mask and pending (PBA) state.
- Arbitrates pending, unmasked vectors round-robin and issues one message request at a time to the TLP generator over a valid/ready handshake.
- Sits between the config-space decoder and the TX message path.

Parameters:
- NUM_VECTORS, 8, vector count, 1..64; Table Size field = NUM_VECTORS-1.
- TABLE_OFFSET, 32'h0000_0000, byte offset of the vector table in its BAR; bits [2:0] must be 0.
- TABLE_BIR, 3'd0, BAR indicator for the table.
- PBA_OFFSET, 32'h0000_0800, byte offset of the PBA; bits [2:0] must be 0.
- PBA_BIR, 3'd0, BAR indicator for the PBA.
- TYPE1, 1'b0, 1 = Type 1 header (BIR legal only 0..1); 0 = Type 0 (BIR legal 0..5).
- NEXT_PTR, 8'h00, next capability pointer.
- IDX_W, $clog2(NUM_VECTORS) min 1, derived vector index width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cfg_rd_en  in  1  config read strobe
- cfg_wr_en  in  1  config write strobe
- cfg_addr  in  2  dword in capability: 0 = header/MsgCtl, 1 = Table Off/BIR, 2 = PBA Off/BIR
- cfg_byte_en  in  4  write byte enables
- cfg_wdata  in  32  write data
- cfg_rdata  out  32  read data, registered
- cfg_rd_valid  out  1  read data valid
- vec_mask_wr_en  in  1  vector-control mask write, from the table BAR decoder
- vec_mask_idx  in  IDX_W  vector being written
- vec_mask_wdata  in  1  new mask bit
- pba_rdata  out  64  combinational PBA qword, pending bits zero-extended
- irq_req  in  NUM_VECTORS  single-cycle interrupt event per vector
- msg_valid  out  1  message request
- msg_vector  out  IDX_W  vector to send
- msg_ready  in  1  TX path accepts
- msix_enable  out  1  MSI-X Enable bit
- function_mask  out  1  Function Mask bit
- param_error  out  1  static parameter violation

Behaviour:
- Reset values:
  - msix_enable = 0, function_mask = 0.
  - All vector masks = 1, all pending = 0.
  - msg_valid = 0, msg_vector = 0, cfg_rdata = 0, cfg_rd_valid = 0.
  - RR pointer = 0, state = IDLE.
- Dword 0 read layout:
  - [31] Enable, [30] Function Mask, [29:27] 0, [26:16] NUM_VECTORS-1.
  - [15:8] NEXT_PTR, [7:0] 8'h11.
- Dword 0 writes:
  - Only byte 3 is writable, when cfg_byte_en[3] = 1.
  - Bits 31 and 30 update; everything else is RO.
- Dwords 1 and 2:
  - Read {OFFSET[31:3], BIR}.
  - Fully RO; writes are ignored. cfg_addr = 3 reads 0.
- Config read latency is 1 cycle: cfg_rd_en in cycle N gives cfg_rdata and cfg_rd_valid in N+1.
- Simultaneous cfg_rd_en and cfg_wr_en to the same dword: the read returns the pre-write value.
- Vector mask writes take effect the next cycle. Writes with vec_mask_idx >= NUM_VECTORS are ignored.
- Pending:
  - irq_req[i] sets pending[i] when msix_enable = 1. irq_req is ignored while enable = 0.
  - pending[i] clears on a msg handshake for vector i.
  - Same-cycle set and clear on the same vector: set wins, so the vector stays pending.
- Eligibility: eligible[i] = pending[i] & ~mask[i] & ~function_mask & msix_enable.
- State machine:
  - IDLE: if any vector is eligible, latch the RR winner into msg_vector, assert msg_valid, go to ISSUE.
  - ISSUE: msg_valid and msg_vector are held stable while msg_ready = 0. On msg_valid & msg_ready: clear pending[msg_vector], set RR pointer = msg_vector+1 (wraps to 0 after NUM_VECTORS-1), go to IDLE.
  - At most one message every 2 cycles.
- Masking mid-ISSUE (vector mask or function mask set): the presented message stays valid until accepted.
- Enable cleared mid-ISSUE: msg_valid drops the next cycle, pending is retained, state returns to IDLE. This is the only permitted valid withdrawal.
- Latency: irq_req in cycle N, pending in N+1, msg_valid in N+2 (from IDLE).
- RR search: starts at the pointer and wraps, lowest index first from the pointer.
- param_error = 1 (constant) when any of:
  - either BIR > 5;
  - TYPE1 and either BIR > 1;
  - either offset[2:0] != 0;
  - TABLE_BIR == PBA_BIR and the byte ranges [TABLE_OFFSET, +16*NUM_VECTORS) and [PBA_OFFSET, +8) overlap.
- Reset asserted mid-operation: all state returns to reset values immediately; no message completes.

Decomposition:
- msix_pkg holds:
  - cap ID 8'h11;
  - dword indices (MSIX_DW_CTRL = 0, MSIX_DW_TABLE = 1, MSIX_DW_PBA = 2);
  - bit positions (ENABLE = 31, FMASK = 30);
  - state enum {IDLE, ISSUE};
  - max BIR constants for Type 0 and Type 1.
- Sub-module msix_rr_arbiter: parameter N, inputs req[N] and ptr, outputs gnt_idx and any_gnt, purely combinational.

Test Plan:
- Reset → read dword 0 gives 32'h0007_0011 (NUM_VECTORS = 8, NEXT_PTR = 0); dword 1 = 32'h0; dword 2 = 32'h0000_0800; param_error = 0.
- Write dword 0 = 32'hC000_0000 (be = 4'hF) → msix_enable = 1, function_mask = 1. Pulse irq_req[3] → pba_rdata = 64'h8, msg_valid stays 0. Clear function mask, unmask vector 3 → msg_valid with msg_vector = 3, 2 cycles later.
- Enable = 1, vectors 1, 2 and 5 unmasked, irq_req = 8'b0010_0110 in one cycle, msg_ready held 1 → messages in order 1, 2, 5, each 2 cycles apart; PBA ends at 0.
- In ISSUE with vector 2 and msg_ready = 0 for 5 cycles, pulse irq_req[2] → msg_vector stable at 2; after handshake pending[2] stays 1 and a second message for 2 follows.
- In ISSUE, clear Enable → msg_valid = 0 the next cycle, pba_rdata still shows the bit; irq_req while disabled sets nothing.
- Instantiate with TYPE1 = 1, TABLE_BIR = 2 → param_error = 1. Separately, TABLE_OFFSET = 0, PBA_OFFSET = 32'h40, same BIR, NUM_VECTORS = 8 → param_error = 1 (overlap).
